// File: rtl/c1_bus_responder.sv
// c1_bus_responder
// Cache-side front end of the CPU<->cache C1 bus. Samples a CPU transaction
// (command, two address beats, optional write data) from the shared bus
// wires, hands it to the cache core over a req/ack handshake, then drives
// the response (C1=7 plus read data) and releases the bus.
//
// Optional feature: define C1_RESP_TIMEOUT_EN to enable a REQ watchdog.
// Without it, REQ waits indefinitely and timeout_err is constant 0.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   c1_in/a1_in/d1_in     bus wires as observed
//   c1_out/c1_oe          C1 drive value / enable
//   d1_out/d1_oe          D1 drive value / enable
//   core_req/core_cmd/core_addr/core_wdata   request to cache core
//   core_ack/core_rdata   single-cycle completion with read data
//   timeout_err           sticky watchdog flag
module c1_bus_responder #(
  parameter int unsigned ADDR_W         = 15,
  parameter int unsigned OFFSET_W       = 4,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [2:0]                 c1_in,
  input  logic [ADDR_W-1:0]          a1_in,
  input  logic [DATA_W-1:0]          d1_in,
  output logic [2:0]                 c1_out,
  output logic                       c1_oe,
  output logic [DATA_W-1:0]          d1_out,
  output logic                       d1_oe,
  output logic                       core_req,
  output logic [2:0]                 core_cmd,
  output logic [ADDR_W+OFFSET_W-1:0] core_addr,
  output logic [2*DATA_W-1:0]        core_wdata,
  input  logic                       core_ack,
  input  logic [2*DATA_W-1:0]        core_rdata,
  output logic                       timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_BEAT2, S_TURN, S_REQ, S_RESP_LO, S_RESP_HI
  } state_e;

  // Code 7 doubles as RESPONSE when driven by this block.
  typedef enum logic [2:0] {
    CMD_NOP, CMD_READ8, CMD_READ16, CMD_READ32,
    CMD_INVAL, CMD_WRITE8, CMD_WRITE16, CMD_WRITE32
  } cmd_e;

  state_e              state_q, state_d;
  logic                req_d;
  logic [2:0]          c1_out_d;
  logic                c1_oe_d;
  logic [DATA_W-1:0]   d1_out_d;
  logic                d1_oe_d;
  logic                resp_start;
  logic [2*DATA_W-1:0] resp_data;
  logic [DATA_W-1:0]   rdata_hi_q;
  logic                tmo_hit;

  // An X/Z command compares unknown and is not taken as a start.
  always_comb begin
    state_d    = state_q;
    req_d      = 1'b0;
    c1_out_d   = '0;
    c1_oe_d    = 1'b0;
    d1_out_d   = '0;
    d1_oe_d    = 1'b0;
    resp_start = 1'b0;
    resp_data  = core_ack ? core_rdata : '0;
    unique case (state_q)
      S_IDLE:  if (c1_in != CMD_NOP) state_d = S_BEAT2;
      S_BEAT2: state_d = S_TURN;
      S_TURN: begin
        state_d = S_REQ;
        req_d   = 1'b1;
      end
      S_REQ: begin
        // Ack has priority over a watchdog expiry in the same cycle.
        if (core_ack || tmo_hit) begin
          resp_start = 1'b1;
          state_d    = S_RESP_LO;
          c1_out_d   = CMD_WRITE32;
          c1_oe_d    = 1'b1;
          case (core_cmd)
            CMD_READ8: begin
              d1_oe_d  = 1'b1;
              d1_out_d = DATA_W'(resp_data[7:0]);
            end
            CMD_READ16, CMD_READ32: begin
              d1_oe_d  = 1'b1;
              d1_out_d = resp_data[DATA_W-1:0];
            end
            default: ;
          endcase
        end else begin
          req_d = 1'b1;
        end
      end
      S_RESP_LO: begin
        if (core_cmd == CMD_READ32) begin
          state_d  = S_RESP_HI;
          c1_out_d = CMD_WRITE32;
          c1_oe_d  = 1'b1;
          d1_oe_d  = 1'b1;
          d1_out_d = rdata_hi_q;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RESP_HI: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      core_req <= 1'b0;
      c1_out   <= '0;
      c1_oe    <= 1'b0;
      d1_out   <= '0;
      d1_oe    <= 1'b0;
    end else begin
      state_q  <= state_d;
      core_req <= req_d;
      c1_out   <= c1_out_d;
      c1_oe    <= c1_oe_d;
      d1_out   <= d1_out_d;
      d1_oe    <= d1_oe_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_cmd   <= '0;
      core_addr  <= '0;
      core_wdata <= '0;
      rdata_hi_q <= '0;
    end else begin
      if (state_q == S_IDLE && c1_in != CMD_NOP) begin
        core_cmd                              <= c1_in;
        core_addr[ADDR_W+OFFSET_W-1:OFFSET_W] <= a1_in;
        core_wdata[DATA_W-1:0]                <= d1_in;
      end
      if (state_q == S_BEAT2) begin
        core_addr[OFFSET_W-1:0]       <= a1_in[OFFSET_W-1:0];
        core_wdata[2*DATA_W-1:DATA_W] <= d1_in;
      end
      if (resp_start) rdata_hi_q <= resp_data[2*DATA_W-1:DATA_W];
    end
  end

`ifdef C1_RESP_TIMEOUT_EN
  localparam int unsigned TMO_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_err_q;

  // Hit on the TIMEOUT_CYCLES-th REQ cycle without an ack.
  assign tmo_hit = (state_q == S_REQ) && !core_ack &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt   <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      if (state_q == S_REQ) tmo_cnt <= tmo_cnt + 1'b1;
      else                  tmo_cnt <= '0;
      if (tmo_hit) tmo_err_q <= 1'b1;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_c1_bus_responder.sv
// Directed self-checking bench for c1_bus_responder.
module tb_c1_bus_responder;

  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned OFFSET_W = 4;
  localparam int unsigned DATA_W   = 16;

  logic                       clk;
  logic                       rst_n;
  logic [2:0]                 c1_in;
  logic [ADDR_W-1:0]          a1_in;
  logic [DATA_W-1:0]          d1_in;
  logic [2:0]                 c1_out;
  logic                       c1_oe;
  logic [DATA_W-1:0]          d1_out;
  logic                       d1_oe;
  logic                       core_req;
  logic [2:0]                 core_cmd;
  logic [ADDR_W+OFFSET_W-1:0] core_addr;
  logic [2*DATA_W-1:0]        core_wdata;
  logic                       core_ack;
  logic [2*DATA_W-1:0]        core_rdata;
  logic                       timeout_err;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  c1_bus_responder #(
    .ADDR_W        (ADDR_W),
    .OFFSET_W      (OFFSET_W),
    .DATA_W        (DATA_W),
`ifdef C1_RESP_TIMEOUT_EN
    .TIMEOUT_CYCLES(8)
`else
    .TIMEOUT_CYCLES(255)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .c1_in      (c1_in),
    .a1_in      (a1_in),
    .d1_in      (d1_in),
    .c1_out     (c1_out),
    .c1_oe      (c1_oe),
    .d1_out     (d1_out),
    .d1_oe      (d1_oe),
    .core_req   (core_req),
    .core_cmd   (core_cmd),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_ack   (core_ack),
    .core_rdata (core_rdata),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents command + two beats; returns just after the edge entering REQ.
  task automatic start_txn(input logic [2:0] cmd,
                           input logic [ADDR_W-1:0] a_b1, input logic [DATA_W-1:0] d_b1,
                           input logic [ADDR_W-1:0] a_b2, input logic [DATA_W-1:0] d_b2);
    c1_in = cmd; a1_in = a_b1; d1_in = d_b1;
    tick();
    c1_in = 3'd0; a1_in = a_b2; d1_in = d_b2;
    tick();
    a1_in = '0; d1_in = '0;
    tick();
  endtask

  task automatic ack_txn(input logic [2*DATA_W-1:0] rd);
    core_ack = 1'b1; core_rdata = rd;
    tick();
    core_ack = 1'b0; core_rdata = '0;
  endtask

  initial begin
    rst_n = 1'b0; c1_in = '0; a1_in = '0; d1_in = '0;
    core_ack = 1'b0; core_rdata = '0;
    #12;
    check("rst_c1_oe",    64'(c1_oe), 64'd0);
    check("rst_d1_oe",    64'(d1_oe), 64'd0);
    check("rst_c1_out",   64'(c1_out), 64'd0);
    check("rst_d1_out",   64'(d1_out), 64'd0);
    check("rst_req",      64'(core_req), 64'd0);
    check("rst_addr",     64'(core_addr), 64'd0);
    check("rst_wdata",    64'(core_wdata), 64'd0);
    check("rst_tmo",      64'(timeout_err), 64'd0);
    rst_n = 1'b1;
    tick();

    // READ8, ack two cycles after core_req appears
    start_txn(3'd1, 15'h0003, 16'h0, 15'h0002, 16'h0);
    check("r8_req",  64'(core_req), 64'd1);
    check("r8_cmd",  64'(core_cmd), 64'd1);
    check("r8_addr", 64'(core_addr), 64'h00032);
    check("r8_oe_in_req", 64'(c1_oe), 64'd0);
    tick();
    tick();
    check("r8_req_held", 64'(core_req), 64'd1);
    ack_txn(32'h1234ABCD);
    check("r8_req_drop", 64'(core_req), 64'd0);
    check("r8_c1",   64'(c1_out), 64'd7);
    check("r8_c1oe", 64'(c1_oe), 64'd1);
    check("r8_d1oe", 64'(d1_oe), 64'd1);
    check("r8_d1",   64'(d1_out), 64'h00CD);
    tick();
    check("r8_rel_c1oe", 64'(c1_oe), 64'd0);
    check("r8_rel_d1oe", 64'(d1_oe), 64'd0);
    tick();

    // READ32
    start_txn(3'd3, 15'h0003, 16'h0, 15'h0002, 16'h0);
    tick();
    tick();
    ack_txn(32'h1234ABCD);
    check("r32_c1_lo", 64'(c1_out), 64'd7);
    check("r32_d1_lo", 64'(d1_out), 64'hABCD);
    check("r32_oe_lo", 64'({c1_oe, d1_oe}), 64'b11);
    tick();
    check("r32_c1_hi", 64'(c1_out), 64'd7);
    check("r32_d1_hi", 64'(d1_out), 64'h1234);
    check("r32_oe_hi", 64'({c1_oe, d1_oe}), 64'b11);
    tick();
    check("r32_rel", 64'({c1_oe, d1_oe}), 64'b00);
    tick();

    // WRITE32, ack in the first REQ cycle
    start_txn(3'd7, 15'h0100, 16'h5555, 15'h0005, 16'hAAAA);
    check("w32_wdata", 64'(core_wdata), 64'hAAAA5555);
    check("w32_cmd",   64'(core_cmd), 64'd7);
    check("w32_addr",  64'(core_addr), 64'h01005);
    ack_txn(32'hFFFFFFFF);
    check("w32_c1",    64'(c1_out), 64'd7);
    check("w32_c1oe",  64'(c1_oe), 64'd1);
    check("w32_d1oe",  64'(d1_oe), 64'd0);
    tick();
    check("w32_rel",   64'(c1_oe), 64'd0);
    tick();

    // NOP stream, stray ack in IDLE, then a second command during REQ
    c1_in = 3'd0; a1_in = 15'h7FFF; d1_in = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) core_ack = 1'b1;
      tick();
      core_ack = 1'b0;
      check("nop_req", 64'(core_req), 64'd0);
    end
    check("nop_c1oe", 64'(c1_oe), 64'd0);
    start_txn(3'd2, 15'h0011, 16'h0, 15'h0009, 16'h0);
    c1_in = 3'd5; a1_in = 15'h0044;
    tick();
    tick();
    c1_in = 3'd0; a1_in = '0;
    check("busy_cmd",  64'(core_cmd), 64'd2);
    check("busy_addr", 64'(core_addr), 64'h00119);
    ack_txn(32'h5A5ABEEF);
    check("r16_d1",    64'(d1_out), 64'hBEEF);
    check("r16_c1oe",  64'(c1_oe), 64'd1);
    tick();
    check("r16_rel",   64'(c1_oe), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("second_no_req", 64'(core_req), 64'd0);
    end

    // Reset during REQ: outputs clear immediately, no response afterwards
    start_txn(3'd1, 15'h0003, 16'h0, 15'h0002, 16'h0);
    check("mid_req", 64'(core_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req",  64'(core_req), 64'd0);
    check("arst_cmd",  64'(core_cmd), 64'd0);
    check("arst_addr", 64'(core_addr), 64'd0);
    #2 rst_n = 1'b1;
    tick();
    ack_txn(32'h1234ABCD);
    for (int i = 0; i < 3; i++) begin
      check("arst_no_resp", 64'({c1_oe, d1_oe, core_req}), 64'b000);
      tick();
    end

`ifdef C1_RESP_TIMEOUT_EN
    // Watchdog: READ32 with no ack
    start_txn(3'd3, 15'h0003, 16'h0, 15'h0002, 16'h0);
    check("tmo_req0", 64'(core_req), 64'd1);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("tmo_req_held", 64'(core_req), 64'd1);
    end
    tick();
    check("tmo_req_drop", 64'(core_req), 64'd0);
    check("tmo_err",      64'(timeout_err), 64'd1);
    check("tmo_c1",       64'(c1_out), 64'd7);
    check("tmo_d1_lo",    64'(d1_out), 64'd0);
    check("tmo_oe",       64'({c1_oe, d1_oe}), 64'b11);
    tick();
    check("tmo_d1_hi",    64'(d1_out), 64'd0);
    tick();
    check("tmo_rel",      64'({c1_oe, d1_oe}), 64'b00);
    check("tmo_sticky",   64'(timeout_err), 64'd1);
`else
    check("tmo_off", 64'(timeout_err), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
